// File: rtl/dmem_arb_pkg.sv
// Shared types and encodings for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, DMA and memory-side signal bundle of dmem_arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [1:0]    c_size;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;

  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_wen, mem_ren;

  modport slave (
    input  c_req, c_we, c_size, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_din, mem_wen, mem_ren,
    input  mem_dout
  );

  modport master (
    output c_req, c_we, c_size, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_size, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_din, mem_wen, mem_ren,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Winner selection between CPU and DMA requests.
// DMEM_ARB_RR_EN selects round-robin; otherwise fixed CPU priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  owner_t last,
`endif
  input  logic   c_req,
  input  logic   d_req,
  output logic   any,
  output owner_t winner
);

  always_comb begin
    any    = c_req | d_req;
    winner = c_req ? OWN_CPU : OWN_DMA;
`ifdef DMEM_ARB_RR_EN
    if (c_req && d_req)
      winner = (last == OWN_CPU) ? OWN_DMA : OWN_CPU;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a word-wide data memory; sub-word stores
// become read-modify-write. DMEM_ARB_RR_EN enables round-robin arbitration.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  state_t        state, state_nxt;
  owner_t        winner;
  logic          any, load_go, rmw_go;
  logic          sel_we;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr, lat_addr;
  logic [DW-1:0] sel_wdata;
  logic [15:0]   lat_wdata;
  logic          lat_half;
  logic          c_gnt, d_gnt, mem_wen, mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

`ifdef DMEM_ARB_RR_EN
  owner_t last;

  dmem_arb_pick u_pick (
    .last   (last),
    .c_req  (bus.c_req),
    .d_req  (bus.d_req),
    .any    (any),
    .winner (winner)
  );

  // Reset value OWN_DMA makes the CPU win the first simultaneous request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            last <= OWN_DMA;
    else if (c_gnt || d_gnt) last <= winner;
  end
`else
  dmem_arb_pick u_pick (
    .c_req  (bus.c_req),
    .d_req  (bus.d_req),
    .any    (any),
    .winner (winner)
  );
`endif

  always_comb begin
    sel_we    = (winner == OWN_DMA) ? bus.d_we    : bus.c_we;
    sel_size  = (winner == OWN_DMA) ? bus.d_size  : bus.c_size;
    sel_addr  = (winner == OWN_DMA) ? bus.d_addr  : bus.c_addr;
    sel_wdata = (winner == OWN_DMA) ? bus.d_wdata : bus.c_wdata;
  end

  always_comb begin
    state_nxt = state;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    load_go   = 1'b0;
    rmw_go    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          c_gnt    = (winner == OWN_CPU);
          d_gnt    = (winner == OWN_DMA);
          mem_addr = sel_addr;
          if (sel_we && !(sel_size inside {SZ_BYTE, SZ_HALF})) begin
            mem_wen = 1'b1;
            mem_din = sel_wdata;
          end else begin
            mem_ren = 1'b1;
            if (sel_we) begin
              rmw_go    = 1'b1;
              state_nxt = RMW_WR;
            end else begin
              load_go = 1'b1;
            end
          end
        end
      end
      RMW_WR: begin
        mem_wen   = 1'b1;
        mem_addr  = lat_addr;
        mem_din   = lat_half ? {bus.mem_dout[DW-1:16], lat_wdata}
                             : {bus.mem_dout[DW-1:8],  lat_wdata[7:0]};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Command outputs are combinational, so reset must mask them directly
    // to suppress the write of an interrupted RMW.
    if (!reset_n) begin
      c_gnt    = 1'b0;
      d_gnt    = 1'b0;
      mem_wen  = 1'b0;
      mem_ren  = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      load_go  = 1'b0;
      rmw_go   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.c_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_half     <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.c_rvalid <= load_go && (winner == OWN_CPU);
      bus.d_rvalid <= load_go && (winner == OWN_DMA);
      if (rmw_go) begin
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata[15:0];
        lat_half  <= (sel_size == SZ_HALF);
      end
    end
  end

  assign bus.c_gnt    = c_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.mem_wen  = mem_wen;
  assign bus.mem_ren  = mem_ren;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_din  = mem_din;
  assign bus.c_rdata  = bus.mem_dout;
  assign bus.d_rdata  = bus.mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural word memory.
// Build with +define+DMEM_ARB_RR_EN to check round-robin ordering.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    owner_t      own;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic [31:0] mem [256];

  dmem_arbiter_if #(.AW(10), .DW(32)) bus ();

  dmem_arbiter #(.AW(10), .DW(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_addr[9:2]] <= bus.mem_din;
    if (bus.mem_ren) bus.mem_dout <= mem[bus.mem_addr[9:2]];
  end

  task automatic idle_inputs();
    bus.c_req = 0; bus.c_we = 0; bus.c_size = SZ_WORD; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_size = SZ_WORD; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 0;
    bus.c_req = 1; bus.d_req = 1;
    #1;
    n_checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.mem_wen, bus.mem_ren} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 000000",
               {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.mem_wen, bus.mem_ren});
    end
    n_checks++;
    if (bus.mem_addr !== 10'h0 || bus.mem_din !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus got addr=%h din=%h want 0/0", bus.mem_addr, bus.mem_din);
    end
    @(negedge clk);
    idle_inputs();
    reset_n = 1;
  endtask

  task automatic test_word_path();
    exp_t e;
    @(negedge clk);
    bus.c_req = 1; bus.c_we = 1; bus.c_size = SZ_WORD; bus.c_addr = 10'h040; bus.c_wdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (bus.c_gnt !== 1 || bus.mem_wen !== 1 || bus.mem_ren !== 0 ||
        bus.mem_addr !== 10'h040 || bus.mem_din !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_store got gnt=%b wen=%b ren=%b addr=%h din=%h want 1 1 0 040 deadbeef",
               bus.c_gnt, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_din);
    end
    @(negedge clk);
    bus.c_we = 0;
    #1;
    n_checks++;
    if (bus.c_gnt !== 1 || bus.mem_ren !== 1 || bus.mem_wen !== 0) begin
      n_fail++;
      $display("FAIL word_load_gnt got gnt=%b ren=%b wen=%b want 1 1 0", bus.c_gnt, bus.mem_ren, bus.mem_wen);
    end
    exp_q.push_back('{OWN_CPU, 32'hDEADBEEF});
    @(negedge clk);
    bus.c_req = 0;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.c_rvalid !== 1 || bus.d_rvalid !== 0 || bus.c_rdata !== e.data) begin
      n_fail++;
      $display("FAIL word_load_data got rv=%b/%b data=%h want 1/0 %h",
               bus.c_rvalid, bus.d_rvalid, bus.c_rdata, e.data);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.c_rvalid !== 0) begin
      n_fail++;
      $display("FAIL rvalid_pulse got %b want 0", bus.c_rvalid);
    end
  endtask

  task automatic test_byte_rmw();
    exp_t e;
    @(negedge clk);
    mem[10'h080 >> 2] = 32'h11223344;
    bus.d_req = 1; bus.d_we = 1; bus.d_size = SZ_BYTE; bus.d_addr = 10'h080; bus.d_wdata = 32'hFFFFFFAB;
    #1;
    n_checks++;
    if (bus.d_gnt !== 1 || bus.c_gnt !== 0 || bus.mem_ren !== 1 || bus.mem_wen !== 0) begin
      n_fail++;
      $display("FAIL byte_rd got dgnt=%b cgnt=%b ren=%b wen=%b want 1 0 1 0",
               bus.d_gnt, bus.c_gnt, bus.mem_ren, bus.mem_wen);
    end
    @(negedge clk);
    bus.d_req = 0; bus.d_wdata = 32'h0;
    bus.c_req = 1; bus.c_we = 0; bus.c_size = SZ_WORD; bus.c_addr = 10'h080;
    #1;
    n_checks++;
    if (bus.mem_wen !== 1 || bus.mem_ren !== 0 || bus.mem_addr !== 10'h080 ||
        bus.mem_din !== 32'h112233AB || bus.c_gnt !== 0) begin
      n_fail++;
      $display("FAIL byte_wr got wen=%b ren=%b addr=%h din=%h cgnt=%b want 1 0 080 112233ab 0",
               bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_din, bus.c_gnt);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.c_gnt !== 1 || bus.mem_ren !== 1) begin
      n_fail++;
      $display("FAIL after_rmw_gnt got gnt=%b ren=%b want 1 1", bus.c_gnt, bus.mem_ren);
    end
    exp_q.push_back('{OWN_CPU, 32'h112233AB});
    @(negedge clk);
    bus.c_req = 0;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.c_rvalid !== 1 || bus.c_rdata !== e.data) begin
      n_fail++;
      $display("FAIL byte_readback got rv=%b data=%h want 1 %h", bus.c_rvalid, bus.c_rdata, e.data);
    end
  endtask

  task automatic test_half_rmw();
    exp_t e;
    @(negedge clk);
    mem[10'h100 >> 2] = 32'h11223344;
    bus.c_req = 1; bus.c_we = 1; bus.c_size = SZ_HALF; bus.c_addr = 10'h100; bus.c_wdata = 32'hCAFEBEEF;
    #1;
    n_checks++;
    if (bus.c_gnt !== 1 || bus.mem_ren !== 1 || bus.mem_wen !== 0) begin
      n_fail++;
      $display("FAIL half_rd got gnt=%b ren=%b wen=%b want 1 1 0", bus.c_gnt, bus.mem_ren, bus.mem_wen);
    end
    @(negedge clk);
    bus.c_we = 0; bus.c_size = SZ_WORD; bus.c_wdata = 32'h0;
    #1;
    n_checks++;
    if (bus.mem_wen !== 1 || bus.mem_din !== 32'h1122BEEF || bus.c_gnt !== 0) begin
      n_fail++;
      $display("FAIL half_wr got wen=%b din=%h gnt=%b want 1 1122beef 0", bus.mem_wen, bus.mem_din, bus.c_gnt);
    end
    @(negedge clk);
    #1;
    if (bus.c_gnt === 1) exp_q.push_back('{OWN_CPU, 32'h1122BEEF});
    @(negedge clk);
    bus.c_req = 0;
    #1;
    n_checks++;
    if (exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL half_load_gnt got queued=%0d want 1", exp_q.size());
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.c_rvalid !== 1 || bus.c_rdata !== e.data) begin
        n_fail++;
        $display("FAIL half_readback got rv=%b data=%h want 1 %h", bus.c_rvalid, bus.c_rdata, e.data);
      end
    end
  endtask

  task automatic test_contention();
    owner_t order[8];
    int     c_left = 4, d_left = 4, idx = 0, cyc = 0;
    exp_t   e;
    for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_RR_EN
      order[i] = (i % 2 == 0) ? OWN_CPU : OWN_DMA;
`else
      order[i] = (i < 4) ? OWN_CPU : OWN_DMA;
`endif
    end
    // A lone DMA grant first, so round-robin favours the CPU next.
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_size = SZ_WORD; bus.d_addr = 10'h100;
    #1;
    n_checks++;
    if (bus.d_gnt !== 1) begin
      n_fail++;
      $display("FAIL pre_dma_gnt got %b want 1", bus.d_gnt);
    end
    bus.c_addr = 10'h040; bus.c_we = 0; bus.c_size = SZ_WORD;
    exp_q.push_back('{OWN_DMA, 32'h1122BEEF});
    while ((idx < 8 || exp_q.size() > 0) && cyc < 20) begin
      @(negedge clk);
      bus.c_req = (c_left > 0);
      bus.d_req = (d_left > 0);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.c_rvalid !== (e.own == OWN_CPU) || bus.d_rvalid !== (e.own == OWN_DMA) ||
            ((e.own == OWN_CPU) ? bus.c_rdata : bus.d_rdata) !== e.data) begin
          n_fail++;
          $display("FAIL cont_rdata cyc=%0d got rv=%b%b c=%h d=%h want own=%0d data=%h",
                   cyc, bus.c_rvalid, bus.d_rvalid, bus.c_rdata, bus.d_rdata, e.own, e.data);
        end
      end
      if (idx < 8) begin
        n_checks++;
        if (bus.c_gnt !== (order[idx] == OWN_CPU) || bus.d_gnt !== (order[idx] == OWN_DMA)) begin
          n_fail++;
          $display("FAIL cont_order idx=%0d got c=%b d=%b want own=%0d", idx, bus.c_gnt, bus.d_gnt, order[idx]);
        end
        if (order[idx] == OWN_CPU) begin
          c_left--;
          exp_q.push_back('{OWN_CPU, 32'hDEADBEEF});
        end else begin
          d_left--;
          exp_q.push_back('{OWN_DMA, 32'h1122BEEF});
        end
        idx++;
      end
      cyc++;
    end
    n_checks++;
    if (cyc >= 20) begin
      n_fail++;
      $display("FAIL cont_timeout got idx=%0d pending=%0d want 8/0", idx, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_rmw();
    exp_t e;
    @(negedge clk);
    mem[10'h0C0 >> 2] = 32'h55667788;
    bus.c_req = 1; bus.c_we = 1; bus.c_size = SZ_BYTE; bus.c_addr = 10'h0C0; bus.c_wdata = 32'h99;
    #1;
    n_checks++;
    if (bus.c_gnt !== 1 || bus.mem_ren !== 1) begin
      n_fail++;
      $display("FAIL mid_rmw_rd got gnt=%b ren=%b want 1 1", bus.c_gnt, bus.mem_ren);
    end
    @(negedge clk);
    bus.c_req = 0;
    reset_n = 0;
    #1;
    n_checks++;
    if (bus.mem_wen !== 0 || bus.mem_ren !== 0 || bus.mem_addr !== 10'h0 || bus.mem_din !== 32'h0 ||
        bus.c_rvalid !== 0 || bus.c_gnt !== 0) begin
      n_fail++;
      $display("FAIL mid_rmw_reset got wen=%b ren=%b addr=%h din=%h rv=%b gnt=%b want all 0",
               bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_din, bus.c_rvalid, bus.c_gnt);
    end
    @(negedge clk);
    reset_n = 1;
    bus.c_req = 1; bus.c_we = 0; bus.c_size = SZ_WORD; bus.c_addr = 10'h0C0;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = SZ_WORD; bus.d_addr = 10'h040;
    #1;
    n_checks++;
    if (bus.c_gnt !== 1 || bus.d_gnt !== 0) begin
      n_fail++;
      $display("FAIL post_reset_first got c=%b d=%b want 1 0", bus.c_gnt, bus.d_gnt);
    end
    exp_q.push_back('{OWN_CPU, 32'h55667788});
    @(negedge clk);
    bus.c_req = 0;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.c_rvalid !== 1 || bus.c_rdata !== e.data) begin
      n_fail++;
      $display("FAIL no_write_after_reset got rv=%b data=%h want 1 %h", bus.c_rvalid, bus.c_rdata, e.data);
    end
    n_checks++;
    if (bus.d_gnt !== 1) begin
      n_fail++;
      $display("FAIL post_reset_dma got %b want 1", bus.d_gnt);
    end
    exp_q.push_back('{OWN_DMA, 32'hDEADBEEF});
    @(negedge clk);
    bus.d_req = 0;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.d_rvalid !== 1 || bus.d_rdata !== e.data) begin
      n_fail++;
      $display("FAIL post_reset_dma_data got rv=%b data=%h want 1 %h", bus.d_rvalid, bus.d_rdata, e.data);
    end
  endtask

  task automatic test_mutex();
    // Mixed random traffic: read and write strobes must never coincide.
    int bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.c_req = 1'($urandom_range(0, 1)); bus.c_we = 1'($urandom_range(0, 1));
      bus.c_size = 2'($urandom_range(0, 3)); bus.c_addr = 10'($urandom);
      bus.d_req = 1'($urandom_range(0, 1)); bus.d_we = 1'($urandom_range(0, 1));
      bus.d_size = 2'($urandom_range(0, 3)); bus.d_addr = 10'($urandom);
      #1;
      if (bus.mem_wen && bus.mem_ren) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ren_wen_mutex got %0d overlapping cycles want 0", bad);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_word_path();
    test_byte_rmw();
    test_half_rmw();
    test_contention();
    test_reset_mid_rmw();
    test_mutex();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
